// File: rtl/lcd_cmd_arbiter.sv
// Character-LCD command arbiter: runs the LCD power-up init sequence, then shares the
// single LCD controller round-robin between NUM_REQ message writers, one {RS,DATA} word at a time.
module lcd_cmd_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DLY_W   = 20,
    parameter int DLY_PWR = 1000000,
    parameter int DLY_CMD = 262142
) (
    input  logic                   iCLK,
    input  logic                   iRST_N,
    input  logic [NUM_REQ-1:0]     iREQ,
    input  logic [9*NUM_REQ-1:0]   iREQ_DATA,
    output logic [NUM_REQ-1:0]     oACK,
    output logic                   oBUSY,
    output logic                   oINIT_DONE,
    output logic [7:0]             oLCD_DATA,
    output logic                   oLCD_RS,
    output logic                   oLCD_START,
    input  logic                   iLCD_DONE
);

    localparam int                PTR_W    = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(NUM_REQ - 1);
    localparam logic [DLY_W-1:0]  PWR_LAST = DLY_W'(DLY_PWR - 1);
    localparam logic [DLY_W-1:0]  CMD_LAST = DLY_W'(DLY_CMD - 1);

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_ISSUE_INIT,
        S_IDLE,
        S_WAIT_DONE,
        S_SETTLE
    } state_t;

    state_t             r_state;
    logic [DLY_W-1:0]   r_cnt;
    logic [PTR_W-1:0]   r_ptr;
    logic [1:0]         r_idx;

    logic [PTR_W-1:0]   w_gnt;
    logic               w_gnt_vld;
    logic [8:0]         w_word;

    // Function set 8-bit/2-line, display on, clear, entry mode increment.
    function automatic logic [7:0] init_word(input logic [1:0] idx);
        case (idx)
            2'd0:    init_word = 8'h38;
            2'd1:    init_word = 8'h0C;
            2'd2:    init_word = 8'h01;
            default: init_word = 8'h06;
        endcase
    endfunction

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        int j;
        j         = 0;
        w_gnt     = '0;
        w_gnt_vld = 1'b0;
        w_word    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(r_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (iREQ[j]) begin
                w_gnt     = PTR_W'(j);
                w_gnt_vld = 1'b1;
                w_word    = iREQ_DATA[9*j +: 9];
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state    <= S_PWR_WAIT;
            r_cnt      <= '0;
            r_ptr      <= '0;
            r_idx      <= '0;
            oACK       <= '0;
            oBUSY      <= 1'b1;
            oINIT_DONE <= 1'b0;
            oLCD_DATA  <= '0;
            oLCD_RS    <= 1'b0;
            oLCD_START <= 1'b0;
        end else begin
            oACK <= '0;
            case (r_state)
                S_PWR_WAIT: begin
                    if (r_cnt == PWR_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_ISSUE_INIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ISSUE_INIT: begin
                    oLCD_DATA  <= init_word(r_idx);
                    oLCD_RS    <= 1'b0;
                    oLCD_START <= 1'b1;
                    r_state    <= S_WAIT_DONE;
                end
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        oLCD_RS     <= w_word[8];
                        oLCD_DATA   <= w_word[7:0];
                        oACK[w_gnt] <= 1'b1;
                        oLCD_START  <= 1'b1;
                        oBUSY       <= 1'b1;
                        r_ptr       <= (w_gnt == PTR_LAST) ? '0 : w_gnt + 1'b1;
                        r_state     <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (iLCD_DONE) begin
                        oLCD_START <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == CMD_LAST) begin
                        r_cnt <= '0;
                        if (oINIT_DONE) begin
                            oBUSY   <= 1'b0;
                            r_state <= S_IDLE;
                        end else if (r_idx == 2'd3) begin
                            oINIT_DONE <= 1'b1;
                            oBUSY      <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_ISSUE_INIT;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_PWR_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Bench for lcd_cmd_arbiter: queue-based requesters, a 3-cycle LCD controller model and a
// round-robin reference model that predicts the issued word/ack sequence and its timing.
module tb_lcd_cmd_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DLY_PWR = 8;
    localparam int DLY_CMD = 4;

    logic                 iCLK;
    logic                 iRST_N;
    logic [NUM_REQ-1:0]   iREQ;
    logic [9*NUM_REQ-1:0] iREQ_DATA;
    logic [NUM_REQ-1:0]   oACK;
    logic                 oBUSY;
    logic                 oINIT_DONE;
    logic [7:0]           oLCD_DATA;
    logic                 oLCD_RS;
    logic                 oLCD_START;
    logic                 iLCD_DONE;

    logic auto_done;
    logic man_done;
    assign iLCD_DONE = auto_done | man_done;

    lcd_cmd_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DLY_W   (8),
        .DLY_PWR (DLY_PWR),
        .DLY_CMD (DLY_CMD)
    ) dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iREQ       (iREQ),
        .iREQ_DATA  (iREQ_DATA),
        .oACK       (oACK),
        .oBUSY      (oBUSY),
        .oINIT_DONE (oINIT_DONE),
        .oLCD_DATA  (oLCD_DATA),
        .oLCD_RS    (oLCD_RS),
        .oLCD_START (oLCD_START),
        .iLCD_DONE  (iLCD_DONE)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    int n_cmp = 0;
    int n_fail = 0;
    int ncyc = 0;
    int mon_err = 0;
    int ctl_cnt = 0;
    int mptr = 0;
    int last_done_tick = -1;
    int busy_fall_tick = -1;
    int rel_tick = 0;
    logic prev_start = 1'b0;
    logic prev_busy = 1'b1;
    logic [1:0] prev_ack = 2'b00;

    logic [7:0] init_b [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    logic [8:0] rq0[$];
    logic [8:0] rq1[$];
    logic [8:0] m0[$];
    logic [8:0] m1[$];
    logic [8:0] iss_q[$];
    logic [8:0] exp_iss[$];
    logic [1:0] ack_q[$];
    logic [1:0] exp_ack[$];
    int gap_q[$];
    int start_tick_q[$];

    // One clock of bench activity at the falling edge: monitor, requesters, controller model.
    task automatic tick();
        @(negedge iCLK);
        ncyc++;
        if (oLCD_START && !prev_start) begin
            iss_q.push_back({oLCD_RS, oLCD_DATA});
            start_tick_q.push_back(ncyc);
            if (last_done_tick >= 0) gap_q.push_back(ncyc - last_done_tick);
        end
        if (prev_start && !oLCD_START && !iLCD_DONE && iRST_N) mon_err++;
        prev_start = oLCD_START;
        if (prev_busy && !oBUSY) busy_fall_tick = ncyc;
        prev_busy = oBUSY;
        if ((oACK & prev_ack) != 2'b00) mon_err++;
        if (oACK != 2'b00 && !oINIT_DONE) mon_err++;
        prev_ack = oACK;
        if (oACK != 2'b00) begin
            ack_q.push_back(oACK);
            if (oACK[0] && rq0.size() > 0) void'(rq0.pop_front());
            if (oACK[1] && rq1.size() > 0) void'(rq1.pop_front());
        end
        auto_done = 1'b0;
        if (ctl_cnt > 0) begin
            ctl_cnt--;
            if (ctl_cnt == 0) begin
                auto_done = 1'b1;
                last_done_tick = ncyc;
            end
        end else if (oLCD_START) begin
            ctl_cnt = 3;
        end
        iREQ[0] = (rq0.size() > 0);
        iREQ[1] = (rq1.size() > 0);
        iREQ_DATA[8:0]  = (rq0.size() > 0) ? rq0[0] : 9'h000;
        iREQ_DATA[17:9] = (rq1.size() > 0) ? rq1[0] : 9'h000;
    endtask

    task automatic run_until_idle(input int budget, output bit timed_out);
        int i;
        timed_out = 1'b1;
        for (i = 0; i < budget; i++) begin
            tick();
            if (rq0.size() == 0 && rq1.size() == 0 && !oBUSY && !oLCD_START && ctl_cnt == 0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic hold_reset();
        iRST_N = 1'b0;
        rq0.delete();
        rq1.delete();
        ctl_cnt = 0;
        auto_done = 1'b0;
        man_done = 1'b0;
        prev_start = 1'b0;
        prev_ack = 2'b00;
        prev_busy = 1'b1;
        mptr = 0;
        repeat (3) tick();
    endtask

    task automatic release_reset();
        iRST_N = 1'b1;
        rel_tick = ncyc;
    endtask

    // Predict the issue order from the queued words, then run the DUT and compare.
    task automatic run_check(input string name, input bit with_init);
        bit to;
        int g;
        iss_q.delete();
        ack_q.delete();
        gap_q.delete();
        start_tick_q.delete();
        exp_iss.delete();
        exp_ack.delete();
        last_done_tick = -1;
        mon_err = 0;
        if (with_init) begin
            for (int i = 0; i < 4; i++) exp_iss.push_back({1'b0, init_b[i]});
        end
        m0 = rq0;
        m1 = rq1;
        while (m0.size() + m1.size() > 0) begin
            g = mptr;
            if ((g == 0 && m0.size() == 0) || (g == 1 && m1.size() == 0)) g = 1 - g;
            if (g == 0) exp_iss.push_back(m0.pop_front());
            else        exp_iss.push_back(m1.pop_front());
            exp_ack.push_back(2'b01 << g);
            mptr = (g + 1) % NUM_REQ;
        end

        run_until_idle(600, to);
        n_cmp++;
        if (to) begin
            n_fail++;
            $display("FAIL %s timeout: got busy=%0b start=%0b, required idle", name, oBUSY, oLCD_START);
        end
        n_cmp++;
        if (iss_q.size() !== exp_iss.size()) begin
            n_fail++;
            $display("FAIL %s issue_count: got %0d required %0d", name, iss_q.size(), exp_iss.size());
        end
        for (int i = 0; i < exp_iss.size() && i < iss_q.size(); i++) begin
            n_cmp++;
            if (iss_q[i] !== exp_iss[i]) begin
                n_fail++;
                $display("FAIL %s issue[%0d]: got %03h required %03h", name, i, iss_q[i], exp_iss[i]);
            end
        end
        n_cmp++;
        if (ack_q.size() !== exp_ack.size()) begin
            n_fail++;
            $display("FAIL %s ack_count: got %0d required %0d", name, ack_q.size(), exp_ack.size());
        end
        for (int i = 0; i < exp_ack.size() && i < ack_q.size(); i++) begin
            n_cmp++;
            if (ack_q[i] !== exp_ack[i]) begin
                n_fail++;
                $display("FAIL %s ack[%0d]: got %b required %b", name, i, ack_q[i], exp_ack[i]);
            end
        end
        for (int i = 0; i < gap_q.size(); i++) begin
            n_cmp++;
            if (gap_q[i] !== DLY_CMD + 2) begin
                n_fail++;
                $display("FAIL %s done_to_start[%0d]: got %0d required %0d", name, i, gap_q[i], DLY_CMD + 2);
            end
        end
        n_cmp++;
        if (mon_err !== 0) begin
            n_fail++;
            $display("FAIL %s protocol: got %0d violations required 0", name, mon_err);
        end
        if (with_init) begin
            n_cmp++;
            if (start_tick_q.size() == 0 || start_tick_q[0] - rel_tick !== DLY_PWR + 1) begin
                n_fail++;
                $display("FAIL %s pwr_wait: got %0d required %0d", name,
                         (start_tick_q.size() > 0) ? start_tick_q[0] - rel_tick : -1, DLY_PWR + 1);
            end
            n_cmp++;
            if (oINIT_DONE !== 1'b1) begin
                n_fail++;
                $display("FAIL %s init_done: got %b required 1", name, oINIT_DONE);
            end
        end
    endtask

    task automatic test_reset();
        hold_reset();
        n_cmp++;
        if ({oACK, oLCD_START, oINIT_DONE, oBUSY} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ack=%b start=%b done=%b busy=%b required 00 0 0 1",
                     oACK, oLCD_START, oINIT_DONE, oBUSY);
        end
        n_cmp++;
        if ({oLCD_RS, oLCD_DATA} !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_data: got %03h required 000", {oLCD_RS, oLCD_DATA});
        end
    endtask

    task automatic test_init();
        release_reset();
        run_check("init", 1'b1);
        n_cmp++;
        if (oBUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL init_busy: got %b required 0", oBUSY);
        end
    endtask

    task automatic test_single();
        rq0.push_back(9'h154);
        run_check("single", 1'b0);
        n_cmp++;
        if ({oLCD_RS, oLCD_DATA} !== 9'h154) begin
            n_fail++;
            $display("FAIL single_hold: got %03h required 154", {oLCD_RS, oLCD_DATA});
        end
        n_cmp++;
        if (busy_fall_tick - last_done_tick !== DLY_CMD + 1) begin
            n_fail++;
            $display("FAIL single_busy_fall: got %0d required %0d", busy_fall_tick - last_done_tick, DLY_CMD + 1);
        end
    endtask

    task automatic test_round_robin();
        rq1.push_back(9'h0A0);
        run_check("rr_prime", 1'b0);
        rq0.push_back(9'h131);
        rq0.push_back(9'h131);
        rq1.push_back(9'h132);
        rq1.push_back(9'h132);
        run_check("rr_alt", 1'b0);
        n_cmp++;
        if (iss_q.size() != 4 || iss_q[0] !== 9'h131 || iss_q[1] !== 9'h132) begin
            n_fail++;
            $display("FAIL rr_order: got %0d words first %03h required 131,132,131,132",
                     iss_q.size(), (iss_q.size() > 0) ? iss_q[0] : 9'h000);
        end
    endtask

    task automatic test_random();
        int n0;
        int n1;
        for (int r = 0; r < 5; r++) begin
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            if (n0 + n1 == 0) n0 = 1;
            for (int i = 0; i < n0; i++) rq0.push_back(9'($urandom));
            for (int i = 0; i < n1; i++) rq1.push_back(9'($urandom));
            run_check("random", 1'b0);
        end
    endtask

    task automatic test_done_idle();
        int bad;
        bad = 0;
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        repeat (8) begin
            tick();
            if (oLCD_START !== 1'b0 || oBUSY !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL done_in_idle: got %0d bad cycles (start=%b busy=%b) required 0", bad, oLCD_START, oBUSY);
        end
        rq0.push_back(9'h0E7);
        run_check("after_stray_done", 1'b0);
    endtask

    task automatic test_pwr_wait_req();
        hold_reset();
        rq1.push_back(9'h1C3);
        release_reset();
        run_check("req_in_pwr_wait", 1'b1);
    endtask

    task automatic test_reset_mid();
        int i;
        rq0.push_back(9'h1A5);
        for (i = 0; i < 50 && !oLCD_START; i++) tick();
        n_cmp++;
        if (oLCD_START !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_start_seen: got %b required 1", oLCD_START);
        end
        #2;
        iRST_N = 1'b0;
        #1;
        n_cmp++;
        if ({oLCD_START, oINIT_DONE, oBUSY} !== 3'b001) begin
            n_fail++;
            $display("FAIL midrst_async: got start=%b done=%b busy=%b required 0 0 1",
                     oLCD_START, oINIT_DONE, oBUSY);
        end
        hold_reset();
        release_reset();
        run_check("rerun_init", 1'b1);
    endtask

    initial begin
        iRST_N = 1'b0;
        iREQ = '0;
        iREQ_DATA = '0;
        auto_done = 1'b0;
        man_done = 1'b0;
        test_reset();
        test_init();
        test_single();
        test_round_robin();
        test_random();
        test_done_idle();
        test_pwr_wait_req();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
